// File: rtl/complex_mult_pkg.sv
// Shared definitions for the complex-multiplier arbiter: FSM encoding and width helpers.
package complex_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_DELIVER  = 2'd3
  } state_t;

  // Operand parts per requester: {op_1_re, op_1_im, op_2_re, op_2_im}
  localparam int OPS_PER_REQ = 4;

  // Full-precision complex product part: two products plus sum growth
  function automatic int res_width(input int data_width);
    return 2 * data_width + 2;
  endfunction

endpackage

// File: rtl/complex_mult_arbiter_if.sv
// Requester-side and multiplier-side bundles for the shared complex multiplier arbiter.
interface complex_mult_req_if import complex_mult_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int RES_WIDTH  = res_width(DATA_WIDTH)
) ();
  logic [NUM_REQ-1:0]                        req_op_val;
  logic [NUM_REQ-1:0]                        req_op_ready;
  logic [NUM_REQ*OPS_PER_REQ*DATA_WIDTH-1:0] req_ops;
  logic [NUM_REQ-1:0]                        req_res_val;
  logic [NUM_REQ-1:0]                        req_res_ready;
  logic [RES_WIDTH-1:0]                      res_re;
  logic [RES_WIDTH-1:0]                      res_im;

  modport master (
    output req_op_val, req_ops, req_res_ready,
    input  req_op_ready, req_res_val, res_re, res_im
  );

  modport slave (
    input  req_op_val, req_ops, req_res_ready,
    output req_op_ready, req_res_val, res_re, res_im
  );
endinterface

interface complex_mult_mul_if import complex_mult_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = res_width(DATA_WIDTH)
) ();
  logic                  mult_sw_rst;
  logic                  mult_op_val;
  logic                  mult_op_ready;
  logic [DATA_WIDTH-1:0] mult_op_1_re;
  logic [DATA_WIDTH-1:0] mult_op_1_im;
  logic [DATA_WIDTH-1:0] mult_op_2_re;
  logic [DATA_WIDTH-1:0] mult_op_2_im;
  logic                  mult_res_val;
  logic                  mult_res_ready;
  logic [RES_WIDTH-1:0]  mult_res_re;
  logic [RES_WIDTH-1:0]  mult_res_im;

  modport master (
    output mult_sw_rst, mult_op_val, mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im,
           mult_res_ready,
    input  mult_op_ready, mult_res_val, mult_res_re, mult_res_im
  );

  modport slave (
    input  mult_sw_rst, mult_op_val, mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im,
           mult_res_ready,
    output mult_op_ready, mult_res_val, mult_res_re, mult_res_im
  );
endinterface

// File: rtl/complex_mult_arbiter_rr.sv
// Combinational round-robin pick: first requester after last_grant, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_any && req[cand]) begin
        grant_any      = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/complex_mult_arbiter.sv
// Shares one complex multiplier among NUM_REQ requesters, one transaction in flight.
//
// state       | meaning
// ST_IDLE     | pick a requester round-robin, accept its operands
// ST_ISSUE    | present captured operands to the multiplier
// ST_WAIT_RES | accept the multiplier result into the capture register
// ST_DELIVER  | present the result to the granted requester until it accepts
module complex_mult_arbiter import complex_mult_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int RES_WIDTH  = res_width(DATA_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst,
  complex_mult_req_if.slave  req_bus,
  complex_mult_mul_if.master mul_bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int OPS_W = OPS_PER_REQ * DATA_WIDTH;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant_id;
  logic [OPS_W-1:0]     ops_q;
  logic [RES_WIDTH-1:0] res_re_q;
  logic [RES_WIDTH-1:0] res_im_q;
  logic [NUM_REQ-1:0]   rr_grant_oh;
  logic [IDX_W-1:0]     rr_grant_idx;
  logic                 rr_any;
  logic                 capture_ops;
  logic                 capture_res;
  logic                 hold;

  // Either reset masks every handshake output in the same cycle it is asserted
  assign hold = rst | sw_rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_bus.req_op_val),
    .last_grant (last_grant),
    .grant_oh   (rr_grant_oh),
    .grant_idx  (rr_grant_idx),
    .grant_any  (rr_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         state <= ST_IDLE;
    else if (sw_rst) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt              = state;
    capture_ops            = 1'b0;
    capture_res            = 1'b0;
    req_bus.req_op_ready   = '0;
    req_bus.req_res_val    = '0;
    mul_bus.mult_op_val    = 1'b0;
    mul_bus.mult_res_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rr_any) begin
          req_bus.req_op_ready = rr_grant_oh;
          capture_ops          = 1'b1;
          state_nxt            = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mul_bus.mult_op_val = 1'b1;
        if (mul_bus.mult_op_ready) state_nxt = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        mul_bus.mult_res_ready = 1'b1;
        if (mul_bus.mult_res_val) begin
          capture_res = 1'b1;
          state_nxt   = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        req_bus.req_res_val[grant_id] = 1'b1;
        if (req_bus.req_res_ready[grant_id]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (hold) begin
      capture_ops            = 1'b0;
      capture_res            = 1'b0;
      req_bus.req_op_ready   = '0;
      req_bus.req_res_val    = '0;
      mul_bus.mult_op_val    = 1'b0;
      mul_bus.mult_res_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_id   <= '0;
      ops_q      <= '0;
      res_re_q   <= '0;
      res_im_q   <= '0;
    end else if (sw_rst) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_id   <= '0;
      ops_q      <= '0;
      res_re_q   <= '0;
      res_im_q   <= '0;
    end else begin
      if (capture_ops) begin
        ops_q      <= req_bus.req_ops[rr_grant_idx*OPS_W +: OPS_W];
        grant_id   <= rr_grant_idx;
        last_grant <= rr_grant_idx;
      end
      if (capture_res) begin
        res_re_q <= mul_bus.mult_res_re;
        res_im_q <= mul_bus.mult_res_im;
      end
    end
  end

  assign mul_bus.mult_sw_rst  = sw_rst;
  assign mul_bus.mult_op_1_re = ops_q[4*DATA_WIDTH-1 -: DATA_WIDTH];
  assign mul_bus.mult_op_1_im = ops_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign mul_bus.mult_op_2_re = ops_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign mul_bus.mult_op_2_im = ops_q[DATA_WIDTH-1 -: DATA_WIDTH];
  assign req_bus.res_re       = res_re_q;
  assign req_bus.res_im       = res_im_q;

endmodule
